// File: rtl/fret_event_arbiter.sv
// fret_event_arbiter
//   Captures rising edges on five debounced fret lanes, stamps each press with
//   a free-running timestamp, and hands the events one at a time to a consumer.
//   Lanes are served round-robin, starting after the lane served last.
//
//   Handshake: evt_valid/evt_ready. evt_valid rises only when an event is
//   loaded. After that, evt_lane and evt_time hold steady until a rising clk
//   edge that sees evt_valid==1 and evt_ready==1, which completes the transfer.
//   evt_ready has no effect while evt_valid==0.
//
// Parameters
//   TS_W      width of the timestamp counter and evt_time
//   DROP_W    width of the saturating drop counter
// Ports
//   clk       clock; all state changes on its rising edge
//   rst       synchronous active-low reset
//   en        1: capture presses and grant events; 0: flush pending presses
//   lane_db   debounced fret levels, one bit per lane 0..4
//   evt_ready consumer accepts the presented event
//   evt_valid an event is presented
//   evt_lane  lane index 0..4 of the presented event
//   evt_time  timestamp captured at that lane's press
//   fret_held registered copy of lane_db
//   drop_cnt  saturating count of presses lost to an already pending lane
module fret_event_arbiter #(
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4:0]        lane_db,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [2:0]        evt_lane,
  output logic [TS_W-1:0]   evt_time,
  output logic [4:0]        fret_held,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        fret_held_q;
  logic [4:0]        pending_q, pending_d;
  logic [TS_W-1:0]   lane_ts_q [5];
  logic [TS_W-1:0]   lane_ts_d [5];
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [TS_W-1:0]   ts_q;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [2:0]        evt_lane_q, evt_lane_d;
  logic [TS_W-1:0]   evt_time_q, evt_time_d;

  logic [4:0]        rise;
  logic              grant_hit;
  logic [2:0]        grant_lane;
  logic              grant_fire;
  logic              accept;
  logic [4:0]        granted_mask;
  logic              drop_any;

  // Lane index (ptr + k) mod 5 for ptr in 0..4 and k in 0..4.
  function automatic logic [2:0] lane_wrap(input logic [2:0] ptr, input logic [2:0] k);
    logic [3:0] sum;
    sum = {1'b0, ptr} + {1'b0, k};
    if (sum >= 4'd5) sum = sum - 4'd5;
    return sum[2:0];
  endfunction

  assign rise = lane_db & ~fret_held_q;

  // Round-robin search: first pending lane at or after rr_ptr.
  always_comb begin
    grant_hit  = 1'b0;
    grant_lane = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (!grant_hit && pending_q[lane_wrap(rr_ptr_q, 3'(k))]) begin
        grant_hit  = 1'b1;
        grant_lane = lane_wrap(rr_ptr_q, 3'(k));
      end
    end
  end

  // FSM next state and the one-cycle grant/accept strobes.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && grant_hit) begin
          state_d    = GRANT;
          grant_fire = 1'b1;
        end
      end
      GRANT: begin
        if (evt_ready) begin
          state_d = IDLE;
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending/timestamp bookkeeping. A press on the lane being granted this
  // cycle re-arms it with the fresh timestamp; the grant already took the
  // old one, so nothing is lost and no drop is counted.
  always_comb begin
    granted_mask = grant_fire ? (5'd1 << grant_lane) : 5'd0;
    pending_d    = pending_q & ~granted_mask;
    lane_ts_d    = lane_ts_q;
    drop_any     = 1'b0;
    if (!en) begin
      pending_d = 5'd0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rise[i]) begin
          if (!pending_q[i] || granted_mask[i]) begin
            pending_d[i] = 1'b1;
            lane_ts_d[i] = ts_q;
          end else begin
            drop_any = 1'b1;
          end
        end
      end
    end
  end

  // Drops in the same cycle count once; the counter sticks at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_any && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_comb begin
    evt_lane_d = evt_lane_q;
    evt_time_d = evt_time_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_fire) begin
      evt_lane_d = grant_lane;
      evt_time_d = lane_ts_q[grant_lane];
    end
    if (accept) begin
      rr_ptr_d = (evt_lane_q == 3'd4) ? 3'd0 : evt_lane_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      fret_held_q <= 5'd0;
      pending_q   <= 5'd0;
      rr_ptr_q    <= 3'd0;
      ts_q        <= '0;
      drop_cnt_q  <= '0;
      evt_lane_q  <= 3'd0;
      evt_time_q  <= '0;
      for (int i = 0; i < 5; i++) lane_ts_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fret_held_q <= lane_db;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      ts_q        <= ts_q + 1'b1;
      drop_cnt_q  <= drop_cnt_d;
      evt_lane_q  <= evt_lane_d;
      evt_time_q  <= evt_time_d;
      for (int i = 0; i < 5; i++) lane_ts_q[i] <= lane_ts_d[i];
    end
  end

  assign evt_valid = (state_q == GRANT);
  assign evt_lane  = evt_lane_q;
  assign evt_time  = evt_time_q;
  assign fret_held = fret_held_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fret_event_arbiter.sv
// Bench for fret_event_arbiter: directed scenarios plus a randomized run,
// all checked every cycle against a lane-level reference model, with a
// scoreboard queue of expected {lane, time} transfers.
module tb_fret_event_arbiter;
  localparam int TS_W   = 16;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              en;
  logic [4:0]        lane_db;
  logic              evt_ready;
  logic              evt_valid;
  logic [2:0]        evt_lane;
  logic [TS_W-1:0]   evt_time;
  logic [4:0]        fret_held;
  logic [DROP_W-1:0] drop_cnt;

  fret_event_arbiter #(.TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lane_db   (lane_db),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_lane  (evt_lane),
    .evt_time  (evt_time),
    .fret_held (fret_held),
    .drop_cnt  (drop_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // State as seen right after the most recent clock edge.
  bit m_valid;
  int m_lane, m_time, m_rr, m_ts, m_drop;
  bit m_held [5];
  bit m_pend [5];
  int m_lts  [5];

  logic [3+TS_W-1:0] exp_q [$];   // expected transfers, oldest first
  logic [3+TS_W-1:0] acc_q [$];   // transfers the DUT actually made

  task automatic model_step();
    int g;
    bit acc;
    bit drop;
    bit np [5];
    int nl [5];
    if (!rst) begin
      m_valid = 0; m_lane = 0; m_time = 0; m_rr = 0; m_ts = 0; m_drop = 0;
      for (int i = 0; i < 5; i++) begin
        m_held[i] = 0; m_pend[i] = 0; m_lts[i] = 0;
      end
      exp_q.delete();
      return;
    end
    g = -1;
    if (!m_valid && en) begin
      for (int k = 0; k < 5; k++) begin
        int l;
        l = (m_rr + k) % 5;
        if (g < 0 && m_pend[l]) g = l;
      end
    end
    acc  = m_valid && evt_ready;
    drop = 0;
    for (int i = 0; i < 5; i++) begin
      bit r;
      r = lane_db[i] && !m_held[i];
      np[i] = m_pend[i];
      nl[i] = m_lts[i];
      if (!en) np[i] = 0;
      else if (r && (!m_pend[i] || i == g)) begin
        np[i] = 1;
        nl[i] = m_ts;
      end
      else if (r) drop = 1;
      else if (i == g) np[i] = 0;
    end
    if (acc) begin
      m_valid = 0;
      m_rr = (m_lane + 1) % 5;
    end else if (g >= 0) begin
      m_valid = 1;
      m_lane  = g;
      m_time  = m_lts[g];
      exp_q.push_back({3'(g), TS_W'(m_time)});
    end
    if (drop && m_drop < DROP_MAX) m_drop++;
    for (int i = 0; i < 5; i++) begin
      m_pend[i] = np[i];
      m_lts[i]  = nl[i];
      m_held[i] = lane_db[i];
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  function automatic logic [4:0] m_held_vec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_held[i];
    return v;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [3+TS_W-1:0] got, exp;
    // Transfer about to happen on the coming edge: scoreboard it.
    if (rst && evt_valid && evt_ready) begin
      got = {evt_lane, evt_time};
      acc_q.push_back(got);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        if (n_fail <= 40) $display("FAIL sb_unexpected got=%h expected=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          if (n_fail <= 40) $display("FAIL sb_transfer got=%h expected=%h", got, exp);
        end
      end
    end
    model_step();
    @(posedge clk);
    #1;
    n_cmp++;
    if (evt_valid !== m_valid) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL evt_valid got=%b expected=%b t=%0t", evt_valid, m_valid, $time);
    end
    if (m_valid) begin
      n_cmp++;
      if (evt_lane !== 3'(m_lane) || evt_time !== TS_W'(m_time)) begin
        n_fail++;
        if (n_fail <= 40) $display("FAIL evt_data got=%0d/%0d expected=%0d/%0d t=%0t",
                                   evt_lane, evt_time, m_lane, m_time, $time);
      end
    end
    n_cmp++;
    if (fret_held !== m_held_vec()) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL fret_held got=%b expected=%b", fret_held, m_held_vec());
    end
    n_cmp++;
    if (drop_cnt !== DROP_W'(m_drop)) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL drop_cnt got=%0d expected=%0d t=%0t", drop_cnt, m_drop, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; evt_ready = 1'b0; lane_db = 5'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({evt_valid, evt_lane, evt_time, fret_held, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%0d/%0d/%b/%0d expected=all zero",
               evt_valid, evt_lane, evt_time, fret_held, drop_cnt);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    en = 1'b1; evt_ready = 1'b1; lane_db = 5'd0;
    repeat (10) step();
    lane_db = 5'b00100;            // sampled with ts == 10
    step();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early_valid got=%b expected=0", evt_valid);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_lane !== 3'd2 || evt_time !== 16'd10) begin
      n_fail++;
      $display("FAIL single_event got=%b/%0d/%0d expected=1/2/10", evt_valid, evt_lane, evt_time);
    end
    step();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_accept got=%b expected=0", evt_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    acc_q.delete();
    lane_db = 5'b10011;
    repeat (8) step();
    n_cmp++;
    if (acc_q.size() != 3 || acc_q[0][TS_W+:3] !== 3'd0 || acc_q[1][TS_W+:3] !== 3'd1
        || acc_q[2][TS_W+:3] !== 3'd4) begin
      n_fail++;
      $display("FAIL rr_order got_count=%0d expected=3 lanes 0,1,4", acc_q.size());
    end
    // Pointer must now be 0: lanes 0 and 4 together must serve lane 0 first.
    lane_db = 5'b00000;
    step();
    acc_q.delete();
    lane_db = 5'b10001;
    repeat (6) step();
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[0][TS_W+:3] !== 3'd0) begin
      n_fail++;
      $display("FAIL rr_ptr_wrap got_count=%0d expected first lane 0 of 2", acc_q.size());
    end
  endtask

  task automatic test_backpressure_drop();
    do_reset();
    en = 1'b1; evt_ready = 1'b0;
    lane_db = 5'b01000; step();    // ts 0: lane 3 pressed
    step();                        // lane 3 granted, held by backpressure
    lane_db = 5'b01010; step();    // ts 2: lane 1 first press
    lane_db = 5'b01000; step();
    lane_db = 5'b01010; step();    // second press while pending -> drop
    n_cmp++;
    if (drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL drop_one got=%0d expected=1", drop_cnt);
    end
    evt_ready = 1'b1;
    acc_q.delete();
    repeat (5) step();
    n_cmp++;
    if (acc_q.size() < 2 || acc_q[1] !== {3'd1, 16'd2}) begin
      n_fail++;
      $display("FAIL drop_keeps_ts got_count=%0d expected lane 1 time 2", acc_q.size());
    end
    evt_ready = 1'b0;
    lane_db = 5'b00000; step();
    lane_db = 5'b01000; step();
    step();
    lane_db = 5'b01010; step();
    repeat (300) begin
      lane_db = 5'b01000; step();
      lane_db = 5'b01010; step();
    end
    n_cmp++;
    if (drop_cnt !== 8'd255) begin
      n_fail++; $display("FAIL drop_saturate got=%0d expected=255", drop_cnt);
    end
  endtask

  task automatic test_enable_flush();
    do_reset();
    en = 1'b1; evt_ready = 1'b0;
    lane_db = 5'b01000; step();
    step();                        // lane 3 in flight
    lane_db = 5'b01101; step();    // lanes 0 and 2 pending
    en = 1'b0; step();             // flush
    acc_q.delete();
    evt_ready = 1'b1; step();      // in-flight event completes with en==0
    n_cmp++;
    if (acc_q.size() != 1 || acc_q[0][TS_W+:3] !== 3'd3) begin
      n_fail++; $display("FAIL flush_inflight got_count=%0d expected=1 lane 3", acc_q.size());
    end
    en = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (acc_q.size() != 1 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_events got_count=%0d valid=%b expected=1/0", acc_q.size(), evt_valid);
    end
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    en = 1'b1; evt_ready = 1'b0;
    lane_db = 5'b00010; step();
    step();                        // lane 1 in flight
    lane_db = 5'b00110; step();    // lane 2 pending
    lane_db = 5'b00010; step();
    lane_db = 5'b00110; step();    // drop
    n_cmp++;
    if (drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL mid_pre_drop got=%0d expected=1", drop_cnt);
    end
    rst = 1'b0; lane_db = 5'b00001; step();
    n_cmp++;
    if (evt_valid !== 1'b0 || drop_cnt !== 8'd0 || fret_held !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%0d/%b expected=0/0/00000", evt_valid, drop_cnt, fret_held);
    end
    rst = 1'b1; evt_ready = 1'b1;
    acc_q.delete();
    repeat (6) step();
    n_cmp++;
    if (acc_q.size() != 1 || acc_q[0] !== {3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL mid_held_lane got_count=%0d expected=1 lane 0 time 0", acc_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      lane_db   = lane_db ^ 5'($urandom & $urandom);
      en        = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1; evt_ready = 1'b1; en = 1'b1;
    repeat (12) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain got=%0d left expected=0", exp_q.size());
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b0; en = 1'b0; evt_ready = 1'b0; lane_db = 5'd0;
    test_reset();
    test_single_press();
    test_round_robin();
    test_backpressure_drop();
    test_enable_flush();
    test_reset_mid_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fret_event_arbiter.md
FRET_EVENT_ARBITER -- requirements
Module: fret_event_arbiter

Interface
REQ-001 The block SHALL have parameter TS_W, default 16, giving the width of the timestamp counter and of evt_time.
REQ-002 The block SHALL have parameter DROP_W, default 8, giving the width of drop_cnt.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low; it takes effect only on a clk rising edge while rst==0.
REQ-005 Port en, input, 1 bit: 1 enables event capture and grants; 0 flushes pending events.
REQ-006 Port lane_db, input, 5 bits: debounced fret switch levels, one bit per lane 0..4.
REQ-007 Port evt_ready, input, 1 bit: the consumer accepts the presented event.
REQ-008 Port evt_valid, output, 1 bit: an event is presented.
REQ-009 Port evt_lane, output, 3 bits: lane index 0..4 of the presented event.
REQ-010 Port evt_time, output, TS_W bits: timestamp captured at that lane's press.
REQ-011 Port fret_held, output, 5 bits: the registered copy of lane_db.
REQ-012 Port drop_cnt, output, DROP_W bits: saturating count of lost presses.

Function
REQ-013 The block SHALL register lane_db into fret_held every cycle; rise[i] = lane_db[i] & ~fret_held[i].
REQ-014 The block SHALL run a free-running TS_W-bit counter ts that increments every cycle and wraps from all-ones to 0.
REQ-015 On a cycle where rise[i]==1 and en==1 and pending[i]==0, the block SHALL set pending[i] and load lane_ts[i] with the current ts.
REQ-016 On a cycle where rise[i]==1 and en==1 and pending[i]==1 (lane not being granted that cycle), the block SHALL keep the old lane_ts[i] and increment drop_cnt, saturating at all-ones.
REQ-017 If several lanes qualify for a drop in the same cycle, the block SHALL increment drop_cnt by 1 only.
REQ-018 The FSM SHALL have two states, IDLE and GRANT; evt_valid SHALL be 1 exactly in GRANT.
REQ-019 IDLE -> GRANT SHALL occur when en==1 and pending is nonzero.
REQ-020 The granted lane SHALL be the first pending lane found searching rr_ptr, rr_ptr+1, ... modulo 5.
REQ-021 On the IDLE -> GRANT edge, the block SHALL load evt_lane and evt_time from the granted lane and clear that lane's pending bit.
REQ-022 If the granted lane also has rise==1 in that same cycle, the new press SHALL set pending again with the new ts; the grant is unaffected and no drop is counted.
REQ-023 In GRANT, evt_lane and evt_time SHALL stay stable until evt_valid and evt_ready are both 1.
REQ-024 On the accepting edge, the FSM SHALL return to IDLE and set rr_ptr = (evt_lane+1) mod 5.
REQ-025 Back-to-back events SHALL therefore occupy at least 2 cycles each.
REQ-026 Latency SHALL be 2 cycles: a rise sampled at edge k gives evt_valid==1 after edge k+1, given IDLE and no competing lanes.
REQ-027 While en==0, the block SHALL clear all pending bits, set no new ones, count no drops, and make no IDLE -> GRANT transitions.
REQ-028 While en==0, an event already in GRANT SHALL still complete normally through the handshake.
REQ-029 evt_ready while in IDLE SHALL have no effect.
REQ-030 rr_ptr SHALL only ever hold values 0..4.

Reset
REQ-031 On a clk edge with rst==0, the block SHALL set state=IDLE, evt_valid=0, evt_lane=0, evt_time=0, fret_held=0, pending=0, lane_ts=0, rr_ptr=0, ts=0, drop_cnt=0.
REQ-032 Reset SHALL override all other inputs, including in the middle of a GRANT handshake; the in-flight event is discarded.
REQ-033 Because fret_held resets to 0, a lane held high through reset release SHALL produce one press event once en==1.

Verification
REQ-034 Single press: rst released, en=1, evt_ready=1, lane_db=00100 at edge 10 (ts=10) -> evt_valid=1 after edge 11, evt_lane=2, evt_time=10, accepted at edge 12.
REQ-035 Round-robin: lanes 0,1,4 rise together, evt_ready=1 -> grant order 0,1,4; rr_ptr ends at 0.
REQ-036 Backpressure plus drop: evt_ready=0 holding lane 3's event; lane 1 pressed, released and pressed again -> drop_cnt=1 and lane 1 keeps its first timestamp. With DROP_W=8, 300 drops -> drop_cnt=255.
REQ-037 Enable flush: lanes 0 and 2 pending, en dropped to 0 for 1 cycle -> pending=0, no further events; an in-flight event still completes on evt_ready.
REQ-038 Reset mid-handshake: rst=0 during GRANT with evt_ready=0 -> after that edge evt_valid=0, drop_cnt=0, ts=0; lane_db=00001 held -> one event for lane 0 after release.
